ui7611_cfg_seq: RTL and testbench

- Configuration sequencer for the ADV7611 HDMI receiver.
- Walks the register table ROM and issues one I2C write transaction per entry, for indices 0 to REG_SIZE-1.
- The ROM entry format is {dev_addr[23:16], reg_addr[15:8], data[7:0]}. The device address is already the 8-bit write address (LSB = 0).
- Sits between the table ROM (combinational, 0-cycle) and the board's open-drain SCL/SDA pads. Runs once after reset, and again on request.

---
 rtl/ui7611_pkg.sv | 23 ++
 rtl/ui7611_cfg_seq_if.sv | 14 +
 rtl/ui7611_i2c_wr.sv | 122 ++++++++++++
 rtl/ui7611_cfg_seq.sv | 145 ++++++++++++++
 tb/tb_ui7611_cfg_seq.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ui7611_pkg.sv
// Shared types and constants for the ADV7611 configuration sequencer.
// Holds the state enums, ROM entry field positions and the SCL divider helper.
package ui7611_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_PWRUP, S_LOAD, S_XFER, S_GAP, S_NEXT, S_DONE
    } seq_state_e;

    typedef enum logic [2:0] {
        E_IDLE, E_START, E_BIT, E_ACK, E_STOP
    } eng_state_e;

    localparam int DEV_MSB = 23;
    localparam int REG_MSB = 15;
    localparam int DAT_MSB = 7;

    // Cycles per quarter SCL period.
    function automatic int unsigned quarter_cycles(input int unsigned clk_hz,
                                                   input int unsigned i2c_hz);
        return clk_hz / (4 * i2c_hz);
    endfunction

endpackage

// File: rtl/ui7611_cfg_seq_if.sv
// Table ROM and I2C pad bundle between the sequencer (master) and the board (slave).
interface ui7611_cfg_seq_if;
    logic [8:0]  reg_index;
    logic [31:0] reg_data;
    logic [8:0]  reg_size;
    logic        scl_oe;
    logic        sda_oe;
    logic        sda;

    modport master (output reg_index, scl_oe, sda_oe,
                    input  reg_data, reg_size, sda);
    modport slave  (input  reg_index, scl_oe, sda_oe,
                    output reg_data, reg_size, sda);
endinterface

// File: rtl/ui7611_i2c_wr.sv
// Three-byte I2C write engine (dev, reg, data) with open-drain enables.
// Each state spends four quarter ticks; actions happen on the tick ending a quarter.
module ui7611_i2c_wr
    import ui7611_pkg::*;
#(
    parameter int unsigned Q_CYC = 125
) (
    input  logic       I_clk,
    input  logic       I_rstn,
    input  logic       I_go,
    input  logic [7:0] I_dev,
    input  logic [7:0] I_reg,
    input  logic [7:0] I_dat,
    input  logic       I_sda,
    output logic       O_scl_oe,
    output logic       O_sda_oe,
    output logic       O_busy,
    output logic       O_done,
    output logic       O_nack
);

    eng_state_e  state_q;
    logic [15:0] div_q;
    logic [1:0]  qtr_q;
    logic [2:0]  bit_q;
    logic [1:0]  byte_q;
    logic [7:0]  shift_q;
    logic        scl_q, sda_q, done_q, nack_q;
    logic        tick_s;

    assign tick_s   = (div_q == 16'(Q_CYC - 1));
    assign O_scl_oe = scl_q;
    assign O_sda_oe = sda_q;
    assign O_busy   = (state_q != E_IDLE);
    assign O_done   = done_q;
    assign O_nack   = nack_q;

    // Quarter divider, bit/byte sequencing and pad drive.
    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            state_q <= E_IDLE;
            div_q   <= 16'd0;
            qtr_q   <= 2'd0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            shift_q <= 8'd0;
            scl_q   <= 1'b0;
            sda_q   <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == E_IDLE) begin
                div_q <= 16'd0;
                qtr_q <= 2'd0;
                if (I_go) begin
                    state_q <= E_START;
                    nack_q  <= 1'b0;
                    byte_q  <= 2'd0;
                end
            end else if (tick_s) begin
                div_q <= 16'd0;
                qtr_q <= qtr_q + 2'd1;
                case (state_q)
                    E_START: case (qtr_q)
                        2'd1: sda_q <= 1'b1;
                        2'd3: begin
                            scl_q   <= 1'b1;
                            shift_q <= I_dev;
                            bit_q   <= 3'd7;
                            state_q <= E_BIT;
                        end
                        default: ;
                    endcase
                    E_BIT: case (qtr_q)
                        2'd0: sda_q <= ~shift_q[7];
                        2'd1: scl_q <= 1'b0;
                        2'd3: begin
                            scl_q   <= 1'b1;
                            shift_q <= {shift_q[6:0], 1'b0};
                            if (bit_q == 3'd0) state_q <= E_ACK;
                            else               bit_q   <= bit_q - 3'd1;
                        end
                        default: ;
                    endcase
                    E_ACK: case (qtr_q)
                        2'd0: sda_q  <= 1'b0;
                        2'd1: scl_q  <= 1'b0;
                        2'd2: nack_q <= I_sda;
                        2'd3: begin
                            scl_q <= 1'b1;
                            // A NACK on any byte abandons the rest and closes with STOP
                            if (nack_q || byte_q == 2'd2) begin
                                state_q <= E_STOP;
                            end else begin
                                byte_q  <= byte_q + 2'd1;
                                shift_q <= (byte_q == 2'd0) ? I_reg : I_dat;
                                bit_q   <= 3'd7;
                                state_q <= E_BIT;
                            end
                        end
                        default: ;
                    endcase
                    E_STOP: case (qtr_q)
                        2'd0: sda_q <= 1'b1;
                        2'd1: scl_q <= 1'b0;
                        2'd2: sda_q <= 1'b0;
                        2'd3: begin
                            state_q <= E_IDLE;
                            done_q  <= 1'b1;
                        end
                        default: ;
                    endcase
                    default: state_q <= E_IDLE;
                endcase
            end else begin
                div_q <= div_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/ui7611_cfg_seq.sv
// ADV7611 configuration sequencer: waits out power-up, then writes every ROM
// entry over I2C with bounded retries and logs entries that never ACK.
module ui7611_cfg_seq
    import ui7611_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned I2C_FREQ  = 100000,
    parameter int unsigned PWRUP_CYC = 1000000,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic                   I_clk,
    input  logic                   I_rstn,
    input  logic                   I_start,
    ui7611_cfg_seq_if.master       bus,
    output logic                   O_busy,
    output logic                   O_done,
    output logic                   O_err,
    output logic [8:0]             O_err_index,
    output logic [7:0]             O_err_cnt
);

    localparam int unsigned Q_CYC   = quarter_cycles(CLK_FREQ, I2C_FREQ);
    localparam int unsigned GAP_CYC = 4 * Q_CYC;
    localparam int PW_W  = $clog2(PWRUP_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int RT_W  = $clog2(RETRY_MAX + 2);

    seq_state_e        state_q;
    logic [PW_W-1:0]   pw_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [RT_W-1:0]   retry_q;
    logic [8:0]        idx_q, err_idx_q;
    logic [7:0]        err_cnt_q;
    logic [23:0]       entry_q;
    logic              go_q, reissue_q, busy_q, done_q, err_q;
    logic              eng_done_s, eng_nack_s, eng_busy_s, unused_s;

    assign bus.reg_index = idx_q;
    assign O_busy        = busy_q;
    assign O_done        = done_q;
    assign O_err         = err_q;
    assign O_err_index   = err_idx_q;
    assign O_err_cnt     = err_cnt_q;
    assign unused_s      = ^{bus.reg_data[31:24], eng_busy_s};

    ui7611_i2c_wr #(.Q_CYC(Q_CYC)) u_eng (
        .I_clk    (I_clk),
        .I_rstn   (I_rstn),
        .I_go     (go_q),
        .I_dev    (entry_q[DEV_MSB -: 8]),
        .I_reg    (entry_q[REG_MSB -: 8]),
        .I_dat    (entry_q[DAT_MSB -: 8]),
        .I_sda    (bus.sda),
        .O_scl_oe (bus.scl_oe),
        .O_sda_oe (bus.sda_oe),
        .O_busy   (eng_busy_s),
        .O_done   (eng_done_s),
        .O_nack   (eng_nack_s)
    );

    // Sequencer FSM with index, retry, power-up and gap counters plus error log.
    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            state_q   <= S_PWRUP;
            pw_cnt_q  <= '0;
            gap_cnt_q <= '0;
            retry_q   <= '0;
            idx_q     <= 9'd0;
            err_idx_q <= 9'd0;
            err_cnt_q <= 8'd0;
            entry_q   <= 24'd0;
            go_q      <= 1'b0;
            reissue_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            go_q <= 1'b0;
            case (state_q)
                S_IDLE: if (I_start) begin
                    state_q   <= S_PWRUP;
                    pw_cnt_q  <= '0;
                    busy_q    <= 1'b1;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                    err_cnt_q <= 8'd0;
                    idx_q     <= 9'd0;
                end
                S_PWRUP: begin
                    busy_q <= 1'b1;
                    if (pw_cnt_q == PW_W'(PWRUP_CYC - 1)) begin
                        state_q <= (bus.reg_size == 9'd0) ? S_DONE : S_LOAD;
                    end else begin
                        pw_cnt_q <= pw_cnt_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    entry_q <= bus.reg_data[DEV_MSB:0];
                    retry_q <= '0;
                    go_q    <= 1'b1;
                    state_q <= S_XFER;
                end
                S_XFER: if (eng_done_s) begin
                    gap_cnt_q <= '0;
                    state_q   <= S_GAP;
                    if (!eng_nack_s) begin
                        reissue_q <= 1'b0;
                    end else if (retry_q != RT_W'(RETRY_MAX)) begin
                        retry_q   <= retry_q + 1'b1;
                        reissue_q <= 1'b1;
                    end else begin
                        reissue_q <= 1'b0;
                        err_q     <= 1'b1;
                        err_idx_q <= idx_q;
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                    end
                end
                S_GAP: if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                    // A retry re-sends the latched entry without touching the ROM
                    if (reissue_q) begin
                        go_q    <= 1'b1;
                        state_q <= S_XFER;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end else begin
                    gap_cnt_q <= gap_cnt_q + 1'b1;
                end
                S_NEXT: if (idx_q == bus.reg_size - 9'd1) begin
                    state_q <= S_DONE;
                end else begin
                    idx_q   <= idx_q + 9'd1;
                    state_q <= S_LOAD;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ui7611_cfg_seq.sv
// Directed bench: ROM model, I2C slave model with programmable NACKs, and a
// scenario table comparing logged bus transactions against an expected list.
module tb_ui7611_cfg_seq;

    localparam int Q  = 3;
    localparam int PW = 40;

    typedef struct {
        logic [7:0] dev, rg, dat;
        int         nb;
        logic       nack;
    } rec_t;

    typedef struct {
        int         size;
        logic [7:0] ndev;
        int         ntxn;
        int         exp_n;
        int         exp_err;
        int         exp_cnt;
        int         exp_eidx;
    } scen_t;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic       busy, done, err;
    logic [8:0] err_index, size = 9'd10;
    logic [7:0] err_cnt;
    logic       slv_drv = 1'b0;

    int n_chk = 0, n_fail = 0, pcyc = 0;

    ui7611_cfg_seq_if bus();

    ui7611_cfg_seq #(.CLK_FREQ(1200), .I2C_FREQ(100), .PWRUP_CYC(PW), .RETRY_MAX(3)) dut (
        .I_clk(clk), .I_rstn(rst_n), .I_start(start), .bus(bus),
        .O_busy(busy), .O_done(done), .O_err(err),
        .O_err_index(err_index), .O_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcyc++;

    function automatic logic [23:0] rom(input logic [8:0] i);
        logic [7:0] d;
        if (i >= 9'd4 && i <= 9'd6) d = 8'h6C;
        else if (i[0])              d = 8'h44;
        else                        d = 8'h98;
        return {d, 8'h10 + i[7:0], 8'hA0 ^ i[7:0]};
    endfunction

    assign bus.reg_size = size;
    assign bus.reg_data = {8'hEE, rom(bus.reg_index)};
    assign bus.sda      = ~(bus.sda_oe | slv_drv);

    // Slave model state
    logic       scl_p = 1'b1, sda_p = 1'b1, act = 1'b0, ackph = 1'b0, nk = 1'b0;
    logic       seen_r = 1'b0, seen_f = 1'b0;
    logic [7:0] sh = 8'd0;
    logic [7:0] b [3];
    int         bitn = 0, nb = 0, txn_no = 0, nack_txn = -1;
    logic [7:0] nack_dev = 8'hFF;
    int         first_start = -1, last_rise = 0, last_fall = 0, bad_w = 0;
    rec_t       log_q[$];

    always @(negedge clk) begin
        logic scl, sda;
        scl = ~bus.scl_oe;
        sda = bus.sda;
        if (scl_p && scl && sda_p && !sda) begin
            act = 1'b1; bitn = 0; nb = 0; nk = 1'b0; ackph = 1'b0;
            seen_r = 1'b0; seen_f = 1'b0;
            if (first_start < 0) first_start = pcyc;
        end else if (scl_p && scl && !sda_p && sda) begin
            if (act) begin
                log_q.push_back('{b[0], b[1], b[2], nb, nk});
                txn_no++;
            end
            act = 1'b0;
        end else if (act && !scl_p && scl) begin
            if (seen_f && (pcyc - last_fall) != 2 * Q) bad_w++;
            last_rise = pcyc; seen_r = 1'b1;
            if (!ackph) begin sh = {sh[6:0], sda}; bitn++; end
        end else if (act && scl_p && !scl) begin
            if (seen_r && (pcyc - last_rise) != 2 * Q) bad_w++;
            last_fall = pcyc; seen_f = 1'b1;
            if (ackph) begin
                slv_drv = 1'b0; ackph = 1'b0; bitn = 0;
            end else if (bitn == 8) begin
                if (nb < 3) b[nb] = sh;
                nb++;
                ackph = 1'b1;
                if (nb == 1 && (sh == nack_dev || txn_no == nack_txn)) nk = 1'b1;
                slv_drv = !nk;
            end
        end
        scl_p = scl;
        sda_p = ~(bus.sda_oe | slv_drv);
    end

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_chk++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
        end
    endtask

    function automatic logic [31:0] key(input rec_t r);
        if (r.nack) return {r.dev, 16'h0000, r.nb[6:0], 1'b1};
        return {r.dev, r.rg, r.dat, r.nb[6:0], 1'b0};
    endfunction

    task automatic wait_done(input int scen);
        int ok;
        ok = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            start = (scen == 1 && c == 300);
            if (done) begin ok = 1; break; end
        end
        start = 1'b0;
        check("done_timeout", ok, 1);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    scen_t tbl[5];

    initial begin
        rec_t exp_q[$];
        logic [23:0] e;
        int t, rel;

        tbl[0] = '{10, 8'hFF, -1, 10, 0, 0, 0};
        tbl[1] = '{10, 8'h6C, -1, 19, 1, 3, 6};
        tbl[2] = '{10, 8'hFF,  7, 11, 0, 0, 6};
        tbl[3] = '{ 0, 8'hFF, -1,  0, 0, 0, 6};
        tbl[4] = '{ 1, 8'hFF, -1,  1, 0, 0, 6};

        repeat (3) @(negedge clk);
        check("rst_reg_index", bus.reg_index, 0);
        check("rst_scl_oe",    bus.scl_oe,    0);
        check("rst_sda_oe",    bus.sda_oe,    0);
        check("rst_busy",      busy,          0);
        check("rst_done",      done,          0);
        check("rst_err",       err,           0);
        check("rst_err_index", err_index,     0);
        check("rst_err_cnt",   err_cnt,       0);

        for (int s = 0; s < 5; s++) begin
            size = tbl[s].size[8:0];
            nack_dev = tbl[s].ndev;
            nack_txn = tbl[s].ntxn;
            log_q.delete(); txn_no = 0; bad_w = 0; first_start = -1;
            exp_q.delete(); t = 0;
            for (int i = 0; i < tbl[s].size; i++) begin
                e = rom(i[8:0]);
                if (e[23:16] == tbl[s].ndev) begin
                    repeat (4) begin exp_q.push_back('{e[23:16], 8'h00, 8'h00, 1, 1'b1}); t++; end
                end else begin
                    if (t == tbl[s].ntxn) begin exp_q.push_back('{e[23:16], 8'h00, 8'h00, 1, 1'b1}); t++; end
                    exp_q.push_back('{e[23:16], e[15:8], e[7:0], 3, 1'b0}); t++;
                end
            end

            if (s == 0) begin
                rst_n = 1'b1; rel = pcyc;
                @(negedge clk);
                check("busy_after_release", busy, 1);
            end else begin
                pulse_start();
                check("restart_clears_done", done, 0);
                check("restart_clears_err",  err,  0);
            end
            wait_done(s);

            check("end_busy",      busy,      0);
            check("end_err",       err,       tbl[s].exp_err);
            check("end_err_cnt",   err_cnt,   tbl[s].exp_cnt);
            check("end_err_index", err_index, tbl[s].exp_eidx);
            check("txn_count",     log_q.size(), tbl[s].exp_n);
            check("model_count",   exp_q.size(), tbl[s].exp_n);
            for (int k = 0; k < log_q.size() && k < exp_q.size(); k++)
                check($sformatf("s%0d_txn%0d", s, k), key(log_q[k]), key(exp_q[k]));
            check("scl_widths", bad_w, 0);
            check("start_seen", (first_start >= 0), (tbl[s].size > 0));
            if (s == 0)
                check("pwrup_start_window",
                      (first_start - rel >= PW) && (first_start - rel <= PW + 4 * Q + 4), 1);
        end

        // Reset during the data byte of index 2: pads release at once, run restarts at 0
        size = 9'd10; nack_dev = 8'hFF; nack_txn = -1;
        log_q.delete(); txn_no = 0;
        pulse_start();
        begin
            int ok;
            ok = 0;
            for (int c = 0; c < 20000; c++) begin
                @(negedge clk);
                if (log_q.size() == 2 && act && nb == 2 && !ackph && bus.scl_oe) begin ok = 1; break; end
            end
            check("reach_mid_byte", ok, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_scl_oe", bus.scl_oe, 0);
        check("rst_mid_sda_oe", bus.sda_oe, 0);
        check("rst_mid_busy",   busy,       0);
        log_q.delete(); txn_no = 0;
        @(negedge clk) rst_n = 1'b1;
        wait_done(5);
        check("rerun_txn_count", log_q.size(), 10);
        if (log_q.size() > 0) begin
            e = rom(9'd0);
            check("rerun_first_entry", key(log_q[0]), {e, 7'd3, 1'b0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
